uart_tx_fifo: RTL and testbench

//   Parametrised UART transmitter with an input FIFO, configurable frame format
//   (5-9 data bits, none/even/odd parity, 1-2 stop bits) and CTS flow control.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 79 +++++++
 rtl/uart_tx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Parity encodings, FSM state codes and parity helper shared by
//               the UART transmit and receive paths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_PAR_NONE = 0;
  localparam int UART_PAR_EVEN = 1;
  localparam int UART_PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Narrower words are zero-extended, which leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (mode == UART_PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered full/empty flags and count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   full,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] w_count_next;
  logic               r_full;
  logic               r_empty;
  logic               w_push;
  logic               w_pop;

  assign w_push  = wr_en && !r_full;
  assign w_pop   = rd_en && !r_empty;
  assign full    = r_full;
  assign empty   = r_empty;
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_cnt_w'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_cnt_w'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : FIFO-buffered UART transmitter, 5-9 data bits, optional parity,
//               1-2 stop bits, CTS-gated frame start, gapless back-to-back frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_BITS-1:0]        s_data,
  input  logic                        cts,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  import uart_pkg::*;

  localparam int c_clks_per_bit = CLK_FREQ / BAUD_RATE;
  localparam int c_baud_w       = (c_clks_per_bit > 1) ? $clog2(c_clks_per_bit) : 1;
  localparam int c_bit_w        = 4;

  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(c_clks_per_bit - 1);
  localparam logic [c_bit_w-1:0]  c_data_last = c_bit_w'(DATA_BITS - 1);
  localparam logic [c_bit_w-1:0]  c_stop_last = c_bit_w'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (PARITY < UART_PAR_NONE || PARITY > UART_PAR_ODD) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (c_clks_per_bit < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be >= 2");
  end

  uart_state_e          r_state;
  uart_state_e          w_next;
  logic [c_baud_w-1:0]  r_baud;
  logic [c_bit_w-1:0]   r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 w_bit_end;
  logic                 w_can_start;
  logic                 w_pop;
  logic                 w_tx;
  logic                 w_done;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [DATA_BITS-1:0] w_fifo_rd;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (s_valid),
    .wr_data (s_data),
    .full    (w_fifo_full),
    .rd_en   (w_pop),
    .rd_data (w_fifo_rd),
    .empty   (w_fifo_empty),
    .count   (fifo_count)
  );

  assign s_ready     = ~w_fifo_full;
  assign w_bit_end   = (r_baud == c_baud_last);
  assign w_can_start = !w_fifo_empty && cts;
  assign tx          = w_tx;
  assign tx_busy     = (r_state != ST_IDLE);
  assign tx_done     = w_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // tx is a pure decode of state so an async reset forces the line idle at once.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_done = 1'b0;
    w_tx   = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_can_start) begin
          w_pop  = 1'b1;
          w_next = ST_START;
        end
      end
      ST_START: begin
        w_tx = 1'b0;
        if (w_bit_end) w_next = ST_DATA;
      end
      ST_DATA: begin
        w_tx = r_shift[0];
        if (w_bit_end && r_bit == c_data_last) begin
          w_next = (PARITY != UART_PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        w_tx = r_par;
        if (w_bit_end) w_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_end && r_bit == c_stop_last) begin
          w_done = 1'b1;
          if (w_can_start) begin
            w_pop  = 1'b1;
            w_next = ST_START;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || w_bit_end) r_baud <= '0;
      else                                 r_baud <= r_baud + c_baud_w'(1);

      // Bit index restarts whenever the FSM changes state.
      if (r_state != w_next) r_bit <= '0;
      else if (w_bit_end)    r_bit <= r_bit + c_bit_w'(1);

      if (w_pop) begin
        r_shift <= w_fifo_rd;
        r_par   <= parity_bit(9'(w_fifo_rd), PARITY);
      end else if (r_state == ST_DATA && w_bit_end) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo at 8 clocks/bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // 8N1, depth 4
  logic       sv_n = 1'b0, cts_n = 1'b0, rdy_n, tx_n, busy_n, done_n;
  logic [7:0] sd_n = '0;
  logic [2:0] cnt_n;
  // 8E1
  logic       sv_e = 1'b0, cts_e = 1'b0, rdy_e, tx_e, busy_e, done_e;
  logic [7:0] sd_e = '0;
  logic [4:0] cnt_e;
  // 8O1
  logic       sv_o = 1'b0, cts_o = 1'b0, rdy_o, tx_o, busy_o, done_o;
  logic [7:0] sd_o = '0;
  logic [4:0] cnt_o;
  // 7N2
  logic       sv_7 = 1'b0, cts_7 = 1'b0, rdy_7, tx_7, busy_7, done_7;
  logic [6:0] sd_7 = '0;
  logic [4:0] cnt_7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(76800), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
    .clk(clk), .reset(reset), .s_valid(sv_n), .s_ready(rdy_n), .s_data(sd_n), .cts(cts_n),
    .tx(tx_n), .tx_busy(busy_n), .tx_done(done_n), .fifo_count(cnt_n));

  uart_tx_fifo #(.CLK_FREQ(76800), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dut_e (
    .clk(clk), .reset(reset), .s_valid(sv_e), .s_ready(rdy_e), .s_data(sd_e), .cts(cts_e),
    .tx(tx_e), .tx_busy(busy_e), .tx_done(done_e), .fifo_count(cnt_e));

  uart_tx_fifo #(.CLK_FREQ(76800), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dut_o (
    .clk(clk), .reset(reset), .s_valid(sv_o), .s_ready(rdy_o), .s_data(sd_o), .cts(cts_o),
    .tx(tx_o), .tx_busy(busy_o), .tx_done(done_o), .fifo_count(cnt_o));

  uart_tx_fifo #(.CLK_FREQ(76800), .BAUD_RATE(9600), .DATA_BITS(7), .PARITY(0),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) dut_7 (
    .clk(clk), .reset(reset), .s_valid(sv_7), .s_ready(rdy_7), .s_data(sd_7), .cts(cts_7),
    .tx(tx_7), .tx_busy(busy_7), .tx_done(done_7), .fifo_count(cnt_7));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input int s);
    case (s)
      0:       return tx_n;
      1:       return tx_e;
      2:       return tx_o;
      default: return tx_7;
    endcase
  endfunction

  function automatic logic get_busy(input int s);
    case (s)
      0:       return busy_n;
      1:       return busy_e;
      2:       return busy_o;
      default: return busy_7;
    endcase
  endfunction

  function automatic logic get_done(input int s);
    case (s)
      0:       return done_n;
      1:       return done_e;
      2:       return done_o;
      default: return done_7;
    endcase
  endfunction

  task automatic set_in(input int s, input logic v, input logic [8:0] d);
    case (s)
      0:       begin sv_n = v; sd_n = d[7:0]; end
      1:       begin sv_e = v; sd_e = d[7:0]; end
      2:       begin sv_o = v; sd_o = d[7:0]; end
      default: begin sv_7 = v; sd_7 = d[6:0]; end
    endcase
  endtask

  task automatic push(input int s, input logic [8:0] d);
    @(negedge clk);
    set_in(s, 1'b1, d);
    @(negedge clk);
    set_in(s, 1'b0, 9'h0);
  endtask

  // Waits up to max_wait cycles for the start bit, then checks every clock of the frame.
  task automatic check_frame(input int s, input logic [8:0] d, input int nb, input int par,
                             input int nstop, input int max_wait, input string tag);
    logic bits [16];
    int   nbits;
    int   len;
    logic found;
    bits[0] = 1'b0;
    for (int i = 0; i < nb; i++) bits[1 + i] = d[i];
    nbits = 1 + nb;
    if (par >= 0) begin
      bits[nbits] = (par != 0);
      nbits++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[nbits] = 1'b1;
      nbits++;
    end
    len   = nbits * 8;
    found = 1'b0;
    for (int i = 0; i <= max_wait; i++) begin
      if (get_tx(s) == 1'b0) begin
        found = 1'b1;
        break;
      end
      if (i < max_wait) @(negedge clk);
    end
    chk({tag, "_start"}, 32'(found), 32'd1);
    if (!found) return;
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      chk({tag, "_tx"},   32'(get_tx(s)),   32'(bits[k / 8]));
      chk({tag, "_done"}, 32'(get_done(s)), 32'(k == len - 1));
      chk({tag, "_busy"}, 32'(get_busy(s)), 32'd1);
    end
  endtask

  logic [7:0] words [6];

  initial begin
    words = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hFF, 8'hEE};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx",    32'(tx_n),   32'd1);
    chk("rst_busy",  32'(busy_n), 32'd0);
    chk("rst_done",  32'(done_n), 32'd0);
    chk("rst_ready", 32'(rdy_n),  32'd1);
    chk("rst_count", 32'(cnt_n),  32'd0);
    chk("rst_rdy_e", 32'(rdy_e),  32'd1);
    chk("rst_cnt_e", 32'(cnt_e),  32'd0);
    chk("rst_rdy_o", 32'(rdy_o),  32'd1);
    chk("rst_cnt_o", 32'(cnt_o),  32'd0);
    chk("rst_rdy_7", 32'(rdy_7),  32'd1);
    chk("rst_cnt_7", 32'(cnt_7),  32'd0);
    chk("rst_tx_7",  32'(tx_7),   32'd1);
    reset = 1'b0;
    cts_n = 1'b1; cts_e = 1'b1; cts_o = 1'b1; cts_7 = 1'b1;

    // 8N1 0xA5
    push(0, 9'h0A5);
    check_frame(0, 9'h0A5, 8, -1, 1, 10, "n1_a5");
    @(negedge clk);
    chk("n1_idle_busy", 32'(busy_n), 32'd0);
    chk("n1_idle_tx",   32'(tx_n),   32'd1);

    // 8E1 / 8O1 0x07
    push(1, 9'h007);
    check_frame(1, 9'h007, 8, 1, 1, 10, "e1_07");
    @(negedge clk);
    chk("e1_idle_busy", 32'(busy_e), 32'd0);
    push(2, 9'h007);
    check_frame(2, 9'h007, 8, 0, 1, 10, "o1_07");
    @(negedge clk);
    chk("o1_idle_busy", 32'(busy_o), 32'd0);

    // 7N2 back-to-back 0x7F, 0x00
    @(negedge clk); sv_7 = 1'b1; sd_7 = 7'h7F;
    @(negedge clk); sd_7 = 7'h00;
    @(negedge clk); sv_7 = 1'b0;
    check_frame(3, 9'h07F, 7, -1, 2, 0, "n2_7f");
    check_frame(3, 9'h000, 7, -1, 2, 1, "n2_00");
    @(negedge clk);
    chk("n2_idle_busy", 32'(busy_7), 32'd0);

    // FIFO full with cts low, then drain in order
    cts_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fill_ready", 32'(rdy_n), 32'(i < 4));
      sv_n = 1'b1;
      sd_n = words[i];
    end
    @(negedge clk);
    sv_n = 1'b0;
    chk("full_count", 32'(cnt_n),  32'd4);
    chk("full_ready", 32'(rdy_n),  32'd0);
    chk("full_busy",  32'(busy_n), 32'd0);
    chk("full_tx",    32'(tx_n),   32'd1);
    cts_n = 1'b1;
    check_frame(0, {1'b0, words[0]}, 8, -1, 1, 3, "drain0");
    check_frame(0, {1'b0, words[1]}, 8, -1, 1, 1, "drain1");
    check_frame(0, {1'b0, words[2]}, 8, -1, 1, 1, "drain2");
    check_frame(0, {1'b0, words[3]}, 8, -1, 1, 1, "drain3");
    @(negedge clk);
    chk("drain_busy",  32'(busy_n), 32'd0);
    chk("drain_count", 32'(cnt_n),  32'd0);

    // cts dropped mid-frame
    @(negedge clk); sv_n = 1'b1; sd_n = 8'h3C;
    @(negedge clk); sd_n = 8'h11;
    @(negedge clk); sv_n = 1'b0; cts_n = 1'b0;
    check_frame(0, 9'h03C, 8, -1, 1, 0, "cts_3c");
    repeat (20) @(negedge clk);
    chk("cts_wait_tx",    32'(tx_n),   32'd1);
    chk("cts_wait_busy",  32'(busy_n), 32'd0);
    chk("cts_wait_count", 32'(cnt_n),  32'd1);
    cts_n = 1'b1;
    check_frame(0, 9'h011, 8, -1, 1, 3, "cts_11");
    @(negedge clk);

    // Reset during data bit 3 of 0x52 (bit 3 = 0), with 0x0F still queued
    @(negedge clk); sv_n = 1'b1; sd_n = 8'h52;
    @(negedge clk); sd_n = 8'h0F;
    @(negedge clk); sv_n = 1'b0;
    chk("pre_rst_start", 32'(tx_n), 32'd0);
    repeat (35) @(negedge clk);
    chk("pre_rst_tx",    32'(tx_n),   32'd0);
    chk("pre_rst_busy",  32'(busy_n), 32'd1);
    chk("pre_rst_count", 32'(cnt_n),  32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_tx",    32'(tx_n),   32'd1);
    chk("mid_rst_busy",  32'(busy_n), 32'd0);
    chk("mid_rst_count", 32'(cnt_n),  32'd0);
    chk("mid_rst_ready", 32'(rdy_n),  32'd1);
    @(negedge clk);
    reset = 1'b0;
    push(0, 9'h055);
    check_frame(0, 9'h055, 8, -1, 1, 10, "post_rst_55");
    @(negedge clk);
    chk("post_rst_busy",  32'(busy_n), 32'd0);
    chk("post_rst_count", 32'(cnt_n),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
